// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM encoding and default width for the serial adder
package serial_adder_ctrl_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder used as the single arithmetic cell of the serial adder
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one full-adder cell, IDLE/SHIFT/DONE control
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg, sreg;
    logic             carry, fs, fc, last;
    logic [CW-1:0]    cnt;

    fa_cell u_fa (
        .x (a_reg[0]),
        .y (b_reg[0]),
        .ci(carry),
        .s (fs),
        .co(fc)
    );

    // final shift cycle: the cell is producing the MSB of the result
    assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? SHIFT : IDLE;
            SHIFT:   next_state = last ? DONE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // outputs decoded from state only, so no input reaches an output combinationally
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // operand capture, bit-serial shifting and result publication on the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sreg  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            sreg  <= '0;
        end else if (state == SHIFT) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            sreg  <= {fs, sreg[WIDTH-1:1]};
            carry <= fc;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {fs, sreg[WIDTH-1:1]};
                cout <= fc;
            end
        end
    end
endmodule
